// File: rtl/cnt_mod_ud.sv
// Modulo-MOD up/down counter with wrap/saturate/one-shot end-of-count modes,
// cascade carry, compare match and sticky overflow.
module cnt_mod_ud #(
    parameter int N    = 8,
    parameter int MOD  = 200,
    parameter int INIT = 0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         clr,
    input  logic         set_n,
    input  logic         stop,
    input  logic         up_dn,
    input  logic [1:0]   mode,
    input  logic [N-1:0] D,
    input  logic [N-1:0] cmp_val,
    output logic [N-1:0] cnt,
    output logic         tc,
    output logic         co,
    output logic         match,
    output logic         ovf,
    output logic         done
);

    // Compares run one bit wider so MOD == 2**N stays representable.
    localparam logic [N:0]   MOD_X  = (N+1)'(MOD);
    localparam logic [N:0]   MAX_X  = (N+1)'(MOD - 1);
    localparam logic [N-1:0] MAX_V  = N'(MOD - 1);
    localparam logic [N-1:0] INIT_V = N'(INIT);

    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_ONE = 2'b10;

    logic [N-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         done_q, done_d;

    logic [N:0]   cnt_x;
    logic [N:0]   term_x;
    logic [N-1:0] step_v;
    logic [N-1:0] load_v;
    logic         hold;

    always_comb begin
        cnt_x  = {1'b0, cnt_q};
        term_x = up_dn ? MAX_X : '0;
        // Only used below TERM, so the N-bit step never overflows or underflows.
        step_v = up_dn ? cnt_q + N'(1) : cnt_q - N'(1);
        load_v = ({1'b0, D} < MOD_X) ? D : MAX_V;
        hold   = stop | done_q;

        tc    = (cnt_x == term_x);
        co    = tc & ~stop & ~done_q & set_n & ~clr;
        match = (cnt_q == cmp_val);

        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        done_d = done_q;

        if (clr) begin
            cnt_d  = INIT_V;
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end else if (!set_n) begin
            cnt_d  = load_v;
            done_d = 1'b0;
        end else if (hold) begin
            cnt_d  = cnt_q;
        end else if (!tc) begin
            cnt_d  = step_v;
        end else begin
            case (mode)
                MODE_SAT: cnt_d = cnt_q;
                MODE_ONE: done_d = 1'b1;
                default: begin
                    cnt_d = up_dn ? '0 : MAX_V;
                    ovf_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q  <= INIT_V;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule
